// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the shared-ALU controller: widths, function codes,
// FSM state encoding and the latched operation record.
package alu_share_ctrl_pkg;

    localparam int unsigned ALU_DATA_W  = 32;
    localparam int unsigned ALU_SHAMT_W = 5;
    localparam int unsigned ALU_FUNCT_W = 6;

    localparam logic [ALU_FUNCT_W-1:0] FUNCT_ADDU = 6'h09;
    localparam logic [ALU_FUNCT_W-1:0] FUNCT_SUBU = 6'h0A;
    localparam logic [ALU_FUNCT_W-1:0] FUNCT_AND  = 6'h11;
    localparam logic [ALU_FUNCT_W-1:0] FUNCT_SLL  = 6'h21;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [ALU_DATA_W-1:0]  src1;
        logic [ALU_DATA_W-1:0]  src2;
        logic [ALU_SHAMT_W-1:0] shamt;
        logic [ALU_FUNCT_W-1:0] funct;
    } alu_op_t;

    function automatic logic funct_supported(input logic [ALU_FUNCT_W-1:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_AND, FUNCT_SLL: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ALU.sv
// Combinational 32-bit ALU: Addu/Subu/And/SLL with Zero and a 33rd-bit Carry.
// Unsupported function codes produce result 0, zero 1, carry 0.
module ALU
    import alu_share_ctrl_pkg::*;
(
    input  logic [ALU_DATA_W-1:0]  src1,
    input  logic [ALU_DATA_W-1:0]  src2,
    input  logic [ALU_SHAMT_W-1:0] shamt,
    input  logic [ALU_FUNCT_W-1:0] funct,
    output logic [ALU_DATA_W-1:0]  result,
    output logic                   zero,
    output logic                   carry
);

    logic [ALU_DATA_W:0] wide;

    // Bit ALU_DATA_W is the carry-out / borrow / bit shifted past the MSB.
    always_comb begin
        wide = '0;
        case (funct)
            FUNCT_ADDU: wide = {1'b0, src1} + {1'b0, src2};
            FUNCT_SUBU: wide = {1'b0, src1} - {1'b0, src2};
            FUNCT_AND:  wide = {1'b0, src1 & src2};
            FUNCT_SLL:  wide = {1'b0, src1} << shamt;
            default:    wide = '0;
        endcase
    end

    assign result = wide[ALU_DATA_W-1:0];
    assign carry  = wide[ALU_DATA_W];
    assign zero   = (wide[ALU_DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter; grant is one-hot (or zero when nobody is valid).
module alu_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie, favour whichever requester did not win last time.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = valid;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one ALU between two requesters with round-robin arbitration.
// Define ALU_ERR_EN to short-circuit unsupported funct codes into an error response.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W,
    parameter int unsigned FUNCT_W = ALU_FUNCT_W
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_src1,
    input  logic [DATA_W-1:0]  req0_src2,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [FUNCT_W-1:0] req0_funct,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_src1,
    input  logic [DATA_W-1:0]  req1_src2,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [FUNCT_W-1:0] req1_funct,

    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [DATA_W-1:0]  resp_result,
    output logic               resp_zero,
    output logic               resp_carry
`ifdef ALU_ERR_EN
    ,
    output logic               resp_err
`endif
);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q;
    logic              id_q;
    alu_op_t           op_q;
    alu_op_t           req_op;
    logic [1:0]        grant;
    logic              accept;
    logic              skip_alu;

    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              carry_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    alu_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept     = (state_q == S_IDLE) && (grant != 2'b00) && !rst;
    assign req0_ready = (state_q == S_IDLE) && grant[0] && !rst;
    assign req1_ready = (state_q == S_IDLE) && grant[1] && !rst;

    always_comb begin
        req_op = '0;
        if (grant[1]) begin
            req_op.src1  = req1_src1;
            req_op.src2  = req1_src2;
            req_op.shamt = req1_shamt;
            req_op.funct = req1_funct;
        end else begin
            req_op.src1  = req0_src1;
            req_op.src2  = req0_src2;
            req_op.shamt = req0_shamt;
            req_op.funct = req0_funct;
        end
    end

`ifdef ALU_ERR_EN
    assign skip_alu = !funct_supported(req_op.funct);
`else
    assign skip_alu = 1'b0;
`endif

    ALU u_alu (
        .src1   (op_q.src1),
        .src2   (op_q.src2),
        .shamt  (op_q.shamt),
        .funct  (op_q.funct),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = skip_alu ? S_RESP : S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= skip_alu;
        end
    end

    assign resp_err = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= req_op;
                id_q         <= grant[1];
                last_grant_q <= grant[1];
                // Error responses bypass EXEC, so clear the payload here.
                if (skip_alu) begin
                    res_q   <= '0;
                    zero_q  <= 1'b0;
                    carry_q <= 1'b0;
                end
            end
            if (state_q == S_EXEC) begin
                res_q   <= alu_result;
                zero_q  <= alu_zero;
                carry_q <= alu_carry;
            end
        end
    end

    assign resp_valid  = (state_q == S_RESP);
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign resp_zero   = zero_q;
    assign resp_carry  = carry_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl (default and ALU_ERR_EN builds).
module tb_alu_share_ctrl;

    localparam logic [5:0] F_ADDU = 6'h09;
    localparam logic [5:0] F_SUBU = 6'h0A;
    localparam logic [5:0] F_AND  = 6'h11;
    localparam logic [5:0] F_SLL  = 6'h21;
    localparam logic [5:0] F_BAD  = 6'h3F;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_src1, req0_src2;
    logic [4:0]  req0_shamt;
    logic [5:0]  req0_funct;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_src1, req1_src2;
    logic [4:0]  req1_shamt;
    logic [5:0]  req1_funct;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic        resp_zero, resp_carry;
`ifdef ALU_ERR_EN
    logic        resp_err;
`endif

    int checks = 0;
    int errors = 0;

    alu_share_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_src1   (req0_src1),
        .req0_src2   (req0_src2),
        .req0_shamt  (req0_shamt),
        .req0_funct  (req0_funct),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_src1   (req1_src1),
        .req1_src2   (req1_src2),
        .req1_shamt  (req1_shamt),
        .req1_funct  (req1_funct),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_carry  (resp_carry)
`ifdef ALU_ERR_EN
        ,
        .resp_err    (resp_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [5:0] f);
        if (n == 0) begin
            req0_src1 = a; req0_src2 = b; req0_shamt = sh; req0_funct = f; req0_valid = 1'b1;
        end else begin
            req1_src1 = a; req1_src2 = b; req1_shamt = sh; req1_funct = f; req1_valid = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_valid"}, resp_valid, 1'b0);
        check1({tag, "_id"}, resp_id, 1'b0);
        check32({tag, "_result"}, resp_result, 32'h0);
        check1({tag, "_zero"}, resp_zero, 1'b0);
        check1({tag, "_carry"}, resp_carry, 1'b0);
        check1({tag, "_rdy0"}, req0_ready, 1'b0);
        check1({tag, "_rdy1"}, req1_ready, 1'b0);
`ifdef ALU_ERR_EN
        check1({tag, "_err"}, resp_err, 1'b0);
`endif
    endtask

    task automatic check_resp(input string tag, input logic id, input logic [31:0] res,
                              input logic z, input logic c);
        check1({tag, "_valid"}, resp_valid, 1'b1);
        check1({tag, "_id"}, resp_id, id);
        check32({tag, "_result"}, resp_result, res);
        check1({tag, "_zero"}, resp_zero, z);
        check1({tag, "_carry"}, resp_carry, c);
`ifdef ALU_ERR_EN
        check1({tag, "_err"}, resp_err, 1'b0);
`endif
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check1({tag, "_released"}, resp_valid, 1'b0);
    endtask

    // Single uncontended op through the normal IDLE -> EXEC -> RESP path.
    task automatic run_op(input string tag, input int n, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [5:0] f,
                          input logic [31:0] res, input logic z, input logic c);
        set_req(n, a, b, sh, f);
        #1;
        check1({tag, "_ready"}, (n == 0) ? req0_ready : req1_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check1({tag, "_exec_novalid"}, resp_valid, 1'b0);
        tick();
        check_resp(tag, (n != 0), res, z, c);
        release_resp(tag);
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b0;
        req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_shamt = '0; req0_funct = '0;
        req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_shamt = '0; req1_funct = '0;

        // Reset state; a valid request must not see ready while rst is high.
        set_req(0, 32'd5, 32'd7, 5'd0, F_ADDU);
        tick();
        tick();
        check_all_zero("reset");

        // Single op: Addu 5+7, response two cycles after accept.
        rst = 1'b0;
        #1;
        check1("single_ready0", req0_ready, 1'b1);
        check1("single_ready1", req1_ready, 1'b0);
        tick();
        check1("single_exec_valid", resp_valid, 1'b0);
        check1("single_exec_rdy0", req0_ready, 1'b0);
        tick();
        check_resp("single", 1'b0, 32'd12, 1'b0, 1'b0);
        check1("single_resp_rdy0", req0_ready, 1'b0);
        req0_valid = 1'b0;
        release_resp("single");

        // Tie from reset: req0 wins first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 32'd3, 32'd3, 5'd0, F_SUBU);
        set_req(1, 32'hFF, 32'h0F, 5'd0, F_AND);
        #1;
        check1("tie1_rdy0", req0_ready, 1'b1);
        check1("tie1_rdy1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        check1("tie1_exec_rdy1", req1_ready, 1'b0);
        tick();
        check_resp("tie1", 1'b0, 32'h0, 1'b1, 1'b0);
        check1("tie1_resp_rdy1", req1_ready, 1'b0);
        release_resp("tie1");
        check1("tie2_rdy1", req1_ready, 1'b1);
        tick();
        // req1 still asserted (with the same op) to set up the next tie.
        set_req(0, 32'hFFFF_FFFF, 32'h1, 5'd0, F_ADDU);
        tick();
        check_resp("tie2", 1'b1, 32'h0F, 1'b0, 1'b0);
        release_resp("tie2");

        // Next tie goes back to req0; its Addu overflows with carry.
        check1("tie3_rdy0", req0_ready, 1'b1);
        check1("tie3_rdy1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        check_resp("carry", 1'b0, 32'h0, 1'b1, 1'b1);

        // Backpressure: response held, nothing accepted.
        for (int i = 0; i < 5; i++) begin
            tick();
            check_resp("bp", 1'b0, 32'h0, 1'b1, 1'b1);
            check1("bp_rdy0", req0_ready, 1'b0);
            check1("bp_rdy1", req1_ready, 1'b0);
        end
        release_resp("bp");
        check1("bp_next_rdy1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_resp("bp_next", 1'b1, 32'h0F, 1'b0, 1'b0);
        release_resp("bp_next");

        // Shifts and borrow.
        run_op("sll31", 1, 32'h1, 32'h0, 5'd31, F_SLL, 32'h8000_0000, 1'b0, 1'b0);
        run_op("sll1", 0, 32'h8000_0001, 32'h0, 5'd1, F_SLL, 32'h2, 1'b0, 1'b1);
        run_op("borrow", 1, 32'd3, 32'd5, 5'd0, F_SUBU, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // Reset in EXEC aborts the op.
        set_req(0, 32'd1, 32'd1, 5'd0, F_ADDU);
        tick();
        req0_valid = 1'b0;
        check1("abort_in_exec", resp_valid, 1'b0);
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        tick();
        check1("abort_noresp", resp_valid, 1'b0);
        run_op("after_abort", 1, 32'd10, 32'd20, 5'd0, F_ADDU, 32'd30, 1'b0, 1'b0);

        // Unsupported function code.
`ifdef ALU_ERR_EN
        set_req(0, 32'd5, 32'd6, 5'd0, F_BAD);
        #1;
        check1("bad_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        check1("bad_valid", resp_valid, 1'b1);
        check1("bad_err", resp_err, 1'b1);
        check32("bad_result", resp_result, 32'h0);
        check1("bad_zero", resp_zero, 1'b0);
        check1("bad_carry", resp_carry, 1'b0);
        release_resp("bad");
        run_op("after_bad", 1, 32'd2, 32'd2, 5'd0, F_ADDU, 32'd4, 1'b0, 1'b0);
`else
        run_op("bad", 0, 32'd5, 32'd6, 5'd0, F_BAD, 32'h0, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
